// File: rtl/register_file.sv
// Eight-entry 16-bit register file (R7 = PC) with a pending-write scoreboard for hazard detection.
// Optional same-cycle write-to-read forwarding and busy masking when REGFILE_BYPASS_EN is defined.
module register_file #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  readAddr1,
    input  logic [2:0]  readAddr2,
    input  logic [2:0]  writeAddr,
    input  logic [15:0] writeData,
    input  logic        writeEn,
    input  logic [15:0] writeR7Data,
    input  logic        writeR7En,
    input  logic        issueEn,
    input  logic [2:0]  issueAddr,
    output logic [15:0] RFOut1,
    output logic [15:0] RFOut2,
    output logic [15:0] PCOut,
    output logic        busy1,
    output logic        busy2
);

    logic [15:0] regs [8];
    logic [7:0]  pending;
    logic [7:0]  set_mask;
    logic [7:0]  clr_mask;
    logic [7:0]  pending_next;

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issueEn)
            set_mask[issueAddr] = 1'b1;
        if (writeEn)
            clr_mask[writeAddr] = 1'b1;
        if (writeR7En)
            clr_mask[7] = 1'b1;
        // Set is OR-ed in after the clear so a new producer outlives a retiring one.
        pending_next = (pending & ~clr_mask) | set_mask;
    end

    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the array is plain flops, so it can be reset like any register.
            for (int i = 0; i < 7; i++)
                regs[i] <= '0;
            regs[7] <= RESET_PC;
            pending <= '0;
        end else begin
            if (writeEn)
                regs[writeAddr] <= writeData;
            // Later assignment wins: the dedicated PC port overrides a general write to R7.
            if (writeR7En)
                regs[7] <= writeR7Data;
            pending <= pending_next;
        end
    end

    function automatic logic [15:0] read_reg(input logic [2:0] addr);
`ifdef REGFILE_BYPASS_EN
        if (writeR7En && addr == 3'd7)
            return writeR7Data;
        else if (writeEn && addr == writeAddr)
            return writeData;
        else
            return regs[addr];
`else
        return regs[addr];
`endif
    endfunction

    always_comb begin
        RFOut1 = read_reg(readAddr1);
        RFOut2 = read_reg(readAddr2);
        PCOut  = read_reg(3'd7);
    end

`ifdef REGFILE_BYPASS_EN
    // A register retiring this cycle is already forwarded, so it reads as not busy.
    assign busy1 = pending[readAddr1] & ~(clr_mask[readAddr1] & ~set_mask[readAddr1]);
    assign busy2 = pending[readAddr2] & ~(clr_mask[readAddr2] & ~set_mask[readAddr2]);
`else
    assign busy1 = pending[readAddr1];
    assign busy2 = pending[readAddr2];
`endif

endmodule
